// File: rtl/mem_wb_unit.sv
// rtl/mem_wb_unit.sv - MEM/WB stage: data-memory handshake, stall, timeout, register write-back
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   wb_en_in, mem_r_en,        EXE/MEM register: write-back enable, load/store requests,
//   mem_w_en, alu_res,         ALU result (address or write-back data), store data,
//   st_val, dst_in             destination register index
//   mem_req, mem_we, mem_addr, data-memory request side (held stable while mem_req is high)
//   mem_wdata
//   mem_rdata, mem_ready       data-memory response (ready is a one-cycle strobe)
//   mem_stall                  freeze for all upstream pipeline registers
//   wb_en, wb_dst, wb_val      register-file write port toward decode
//   mem_err                    sticky timeout flag, cleared only by reset

module mem_wb_unit #(
    parameter logic [31:0] DATA_BASE = 32'd1024,
    parameter int          MAX_WAIT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] alu_res,
    input  logic [31:0] st_val,
    input  logic [3:0]  dst_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_stall,
    output logic        wb_en,
    output logic [3:0]  wb_dst,
    output logic [31:0] wb_val,
    output logic        mem_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   wait_cnt;
    logic            lat_wb_en;
    logic [3:0]      lat_dst;
    logic            access;
    logic            timeout;
    logic [31:0]     addr_off;

    assign access   = mem_r_en | mem_w_en;
    // The counter sits at MAX_WAIT-1 during the MAX_WAIT-th BUSY cycle.
    assign timeout  = (wait_cnt == CW'(MAX_WAIT - 1));
    assign addr_off = alu_res - DATA_BASE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                // Stall in the same cycle the access shows up so upstream holds it.
                mem_stall = access & ~rst;
                if (access) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_req   = 1'b1;
                mem_stall = ~rst;
                if (mem_ready || timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Input mem flags here are stale (they belong to the finished access).
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            wb_en     <= 1'b0;
            wb_dst    <= 4'd0;
            wb_val    <= 32'd0;
            mem_err   <= 1'b0;
            wait_cnt  <= '0;
            lat_wb_en <= 1'b0;
            lat_dst   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        // Both flags set is treated as a store.
                        mem_we    <= mem_w_en;
                        mem_addr  <= {addr_off[31:2], 2'b00};
                        mem_wdata <= st_val;
                        lat_wb_en <= wb_en_in;
                        lat_dst   <= dst_in;
                        wb_en     <= 1'b0;
                        wait_cnt  <= '0;
                    end else begin
                        wb_en  <= wb_en_in;
                        wb_dst <= dst_in;
                        wb_val <= alu_res;
                    end
                end
                BUSY: begin
                    // A ready strobe wins over a coincident timeout.
                    if (mem_ready) begin
                        if (!mem_we) begin
                            wb_en  <= lat_wb_en;
                            wb_dst <= lat_dst;
                            wb_val <= mem_rdata;
                        end else begin
                            wb_en <= 1'b0;
                        end
                    end else if (timeout) begin
                        mem_err <= 1'b1;
                        wb_en   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    wb_en <= 1'b0;
                end
                default: begin
                    wb_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_unit.sv
// tb/tb_mem_wb_unit.sv - directed table-driven bench for mem_wb_unit

module tb_mem_wb_unit;

    logic        clk;
    logic        rst;
    logic        wb_en_in;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [3:0]  dst_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_stall;
    logic        wb_en;
    logic [3:0]  wb_dst;
    logic [31:0] wb_val;
    logic        mem_err;

    int total;
    int bad;

    mem_wb_unit dut (
        .clk       (clk),
        .rst       (rst),
        .wb_en_in  (wb_en_in),
        .mem_r_en  (mem_r_en),
        .mem_w_en  (mem_w_en),
        .alu_res   (alu_res),
        .st_val    (st_val),
        .dst_in    (dst_in),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_stall (mem_stall),
        .wb_en     (wb_en),
        .wb_dst    (wb_dst),
        .wb_val    (wb_val),
        .mem_err   (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wbi;
        logic        r;
        logic        w;
        logic [31:0] alu;
        logic [31:0] st;
        logic [3:0]  dst;
        logic [31:0] rdata;
        int          lat;
        logic        e_we;
        logic [31:0] e_addr;
        logic        e_wb_en;
        logic [31:0] e_val;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_en_in = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        alu_res  = 32'd0;
        st_val   = 32'd0;
        dst_in   = 4'd0;
    endtask

    // Caller is #1 after a rising edge with the DUT in IDLE.
    task automatic run_vec(input vec_t v);
        logic is_mem;
        is_mem   = v.r | v.w;
        wb_en_in = v.wbi;
        mem_r_en = v.r;
        mem_w_en = v.w;
        alu_res  = v.alu;
        st_val   = v.st;
        dst_in   = v.dst;
        #1;
        chk({v.name, ".stall_now"}, 32'(mem_stall), 32'(is_mem));
        tick();
        if (!is_mem) begin
            chk({v.name, ".wb_en"},  32'(wb_en),  32'(v.e_wb_en));
            chk({v.name, ".wb_dst"}, 32'(wb_dst), 32'(v.dst));
            chk({v.name, ".wb_val"}, wb_val, v.e_val);
            chk({v.name, ".stall"},  32'(mem_stall), 32'd0);
        end else begin
            chk({v.name, ".req"},   32'(mem_req), 32'd1);
            chk({v.name, ".we"},    32'(mem_we),  32'(v.e_we));
            chk({v.name, ".addr"},  mem_addr, v.e_addr);
            if (v.w) chk({v.name, ".wdata"}, mem_wdata, v.st);
            chk({v.name, ".bubble"}, 32'(wb_en), 32'd0);
            for (int i = 1; i < v.lat; i++) begin
                tick();
                chk({v.name, ".wait_req"}, 32'(mem_req | (mem_stall << 1)), 32'd3);
                chk({v.name, ".wait_addr"}, mem_addr, v.e_addr);
            end
            @(negedge clk);
            mem_ready = 1'b1;
            mem_rdata = v.rdata;
            tick();
            mem_ready = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
            chk({v.name, ".done_req"},   32'(mem_req),   32'd0);
            chk({v.name, ".done_stall"}, 32'(mem_stall), 32'd0);
            chk({v.name, ".done_wb_en"}, 32'(wb_en), 32'(v.e_wb_en));
            if (!v.w) begin
                chk({v.name, ".done_dst"}, 32'(wb_dst), 32'(v.dst));
                chk({v.name, ".done_val"}, wb_val, v.e_val);
            end
            tick();
            chk({v.name, ".after_wb_en"}, 32'(wb_en), 32'd0);
        end
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        idle_inputs();
        mem_rdata = 32'd0;
        mem_ready = 1'b0;
        rst = 1'b1;

        vecs[0] = '{"pass",      1, 0, 0, 32'h12,   32'h0,  4'd3,  32'h0,    0, 0, 32'h0,        1, 32'h12};
        vecs[1] = '{"load3",     1, 1, 0, 32'd1032, 32'h0,  4'd5,  32'hCAFE, 3, 0, 32'd8,        1, 32'hCAFE};
        vecs[2] = '{"store",     1, 0, 1, 32'd1028, 32'hAA, 4'd6,  32'h0,    2, 1, 32'd4,        0, 32'h0};
        vecs[3] = '{"rw_store",  1, 1, 1, 32'd1031, 32'h55, 4'd2,  32'h77,   1, 1, 32'd4,        0, 32'h0};
        vecs[4] = '{"load_wrap", 1, 1, 0, 32'd0,    32'h0,  4'd9,  32'h1234, 1, 0, 32'hFFFFFC00, 1, 32'h1234};
        vecs[5] = '{"pass_off",  0, 0, 0, 32'hDEAD, 32'h0,  4'd7,  32'h0,    0, 0, 32'h0,        0, 32'hDEAD};
        vecs[6] = '{"load_nowb", 0, 1, 0, 32'd2051, 32'h0,  4'd4,  32'h99,   2, 0, 32'd1024,     0, 32'h99};
        vecs[7] = '{"load_b2b",  1, 1, 0, 32'd1100, 32'h0,  4'd11, 32'h5A5A, 1, 0, 32'd76,       1, 32'h5A5A};

        #1;
        chk("rst.req",   32'(mem_req),   32'd0);
        chk("rst.stall", 32'(mem_stall), 32'd0);
        chk("rst.wb_en", 32'(wb_en),     32'd0);
        chk("rst.err",   32'(mem_err),   32'd0);
        chk("rst.addr",  mem_addr, 32'd0);
        chk("rst.val",   wb_val,   32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Runs back to back: each next instruction appears in the cycle right after DONE.
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Ready strobe while IDLE must not disturb anything.
        idle_inputs();
        wb_en_in  = 1'b1;
        dst_in    = 4'd1;
        alu_res   = 32'h31;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF;
        tick();
        mem_ready = 1'b0;
        chk("stray_ready.val", wb_val, 32'h31);
        chk("stray_ready.req", 32'(mem_req), 32'd0);

        // Timeout: load never answered.
        idle_inputs();
        wb_en_in = 1'b1;
        mem_r_en = 1'b1;
        alu_res  = 32'd1040;
        dst_in   = 4'd8;
        tick();
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            tick();
        end
        chk("timeout.busy_cycles", 32'(n), 32'd15);
        chk("timeout.err",   32'(mem_err),   32'd1);
        chk("timeout.req",   32'(mem_req),   32'd0);
        chk("timeout.wb_en", 32'(wb_en),     32'd0);
        chk("timeout.stall", 32'(mem_stall), 32'd0);
        idle_inputs();
        tick();
        chk("timeout.idle_stall", 32'(mem_stall), 32'd0);
        chk("timeout.idle_wb_en", 32'(wb_en),     32'd0);

        // mem_err stays set across a normal load.
        run_vec(vecs[1]);
        chk("err_sticky", 32'(mem_err), 32'd1);

        // Ready on the 15th BUSY cycle completes normally.
        idle_inputs();
        wb_en_in = 1'b1;
        mem_r_en = 1'b1;
        alu_res  = 32'd1024;
        dst_in   = 4'd12;
        tick();
        for (int i = 1; i < 15; i++) tick();
        chk("late_ready.still_busy", 32'(mem_req), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h600D;
        tick();
        mem_ready = 1'b0;
        chk("late_ready.wb_en", 32'(wb_en), 32'd1);
        chk("late_ready.val",   wb_val, 32'h600D);
        idle_inputs();
        tick();

        // Asynchronous reset in the middle of BUSY.
        wb_en_in = 1'b1;
        mem_r_en = 1'b1;
        alu_res  = 32'd1036;
        dst_in   = 4'd3;
        tick();
        chk("arst.pre_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst.req",   32'(mem_req),   32'd0);
        chk("arst.stall", 32'(mem_stall), 32'd0);
        chk("arst.err",   32'(mem_err),   32'd0);
        chk("arst.addr",  mem_addr, 32'd0);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("arst.idle_req",   32'(mem_req),   32'd0);
        chk("arst.idle_stall", 32'(mem_stall), 32'd0);
        tick();
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
